arb_requester: RTL and testbench

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_requester_pkg.sv | 15 +
 rtl/arb_requester_if.sv | 41 ++++
 rtl/arb_req_chan.sv | 108 ++++++++++
 rtl/arb_requester.sv | 54 +++++
 tb/tb_arb_requester.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_requester_pkg.sv
// Shared arbiter package: channel FSM state encoding and
// default burst-length / grant-wait parameters.
package arb_requester_pkg;

  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_REL  = 2'd3
  } chan_state_t;

endpackage

// File: rtl/arb_requester_if.sv
// Requester bundle: job strobes/lengths and grants in; requests,
// status pulses and the grant-conflict flag out.
interface arb_requester_if
  import arb_requester_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
);

  logic             start_0;
  logic             start_1;
  logic [LEN_W-1:0] len_0;
  logic [LEN_W-1:0] len_1;
  logic             gnt_0;
  logic             gnt_1;
  logic             req_0;
  logic             req_1;
  logic             busy_0;
  logic             busy_1;
  logic             done_0;
  logic             done_1;
  logic             timeout_0;
  logic             timeout_1;
  logic             gnt_conflict;

  modport master (
    output start_0, start_1, len_0, len_1,
    output gnt_0, gnt_1,
    input  req_0, req_1, busy_0, busy_1,
    input  done_0, done_1, timeout_0, timeout_1,
    input  gnt_conflict
  );

  modport slave (
    input  start_0, start_1, len_0, len_1,
    input  gnt_0, gnt_1,
    output req_0, req_1, busy_0, busy_1,
    output done_0, done_1, timeout_0, timeout_1,
    output gnt_conflict
  );

endinterface

// File: rtl/arb_req_chan.sv
// One requester channel: IDLE/REQ/OWN/REL burst FSM.
// Ports: clk, rst, start, len, gnt in; req, busy, done, timeout out.
module arb_req_chan
  import arb_requester_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  chan_state_t      state_q;
  chan_state_t      state_d;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] rem_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic             tmo_d;

  assign wait_inc = wait_q + WAIT_W'(1);

  // rem holds beats still owed minus one, so a grant
  // with rem at zero is the final beat of the burst.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = len;
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          if (rem_q == '0) begin
            state_d = ST_REL;
          end else begin
            rem_d   = rem_q - LEN_W'(1);
            state_d = ST_OWN;
          end
        end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
          wait_d  = '0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_OWN: begin
        if (gnt) begin
          if (rem_q == '0) begin
            state_d = ST_REL;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end else begin
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are flops loaded from the next state so they
  // line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      wait_q  <= '0;
      req     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      req     <= (state_d == ST_REQ) ||
                 (state_d == ST_OWN);
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_REL);
      timeout <= tmo_d;
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Two-channel arbiter requester with a sticky grant-conflict flag.
// Ports: clk, rst and the arb_requester_if slave bundle.
module arb_requester
  import arb_requester_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  arb_requester_if.slave bus
);

  arb_req_chan #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) u_chan_0 (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.start_0),
    .len     (bus.len_0),
    .gnt     (bus.gnt_0),
    .req     (bus.req_0),
    .busy    (bus.busy_0),
    .done    (bus.done_0),
    .timeout (bus.timeout_0)
  );

  arb_req_chan #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) u_chan_1 (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.start_1),
    .len     (bus.len_1),
    .gnt     (bus.gnt_1),
    .req     (bus.req_1),
    .busy    (bus.busy_1),
    .done    (bus.done_1),
    .timeout (bus.timeout_1)
  );

  // The arbiter must never grant both clients; once seen,
  // the flag holds until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt_conflict <= 1'b0;
    end else if (bus.gnt_0 && bus.gnt_1) begin
      bus.gnt_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: vector table, corner sequences and
// random traffic against a beat-counting reference model.
module tb_arb_requester;

  localparam int TMO = 15;

  logic clk;
  logic rst;

  arb_requester_if bus ();

  arb_requester #(
    .LEN_W   (4),
    .TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference: per channel, whether a request is outstanding,
  // beats still owed, grant-less cycles counted, release cycle.
  bit m_act[2];
  bit m_rel[2];
  bit m_tmo[2];
  int m_left[2];
  int m_wait[2];
  bit m_conf;

  task automatic chan_model(input int c, input bit s,
                            input int l, input bit g);
    m_tmo[c] = 1'b0;
    if (m_rel[c]) begin
      m_rel[c] = 1'b0;
    end else if (m_act[c]) begin
      if (g) begin
        m_left[c] = m_left[c] - 1;
        // first grant-less cycle after a beat only hands
        // the bus back, it is not counted as waiting
        m_wait[c] = -1;
        if (m_left[c] == 0) begin
          m_act[c] = 1'b0;
          m_rel[c] = 1'b1;
        end
      end else begin
        m_wait[c] = m_wait[c] + 1;
        if (m_wait[c] == TMO) begin
          m_act[c] = 1'b0;
          m_tmo[c] = 1'b1;
        end
      end
    end else if (s) begin
      m_act[c]  = 1'b1;
      m_left[c] = l + 1;
      m_wait[c] = 0;
    end
  endtask

  task automatic model_step(input bit r,
    input bit s0, input int l0, input bit g0,
    input bit s1, input int l1, input bit g1);
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_act[c]  = 1'b0;
        m_rel[c]  = 1'b0;
        m_tmo[c]  = 1'b0;
        m_left[c] = 0;
        m_wait[c] = 0;
      end
      m_conf = 1'b0;
    end else begin
      if (g0 && g1) m_conf = 1'b1;
      chan_model(0, s0, l0, g0);
      chan_model(1, s1, l1, g1);
    end
  endtask

  function automatic logic [8:0] model_vec();
    return {m_act[0], m_act[0] | m_rel[0],
            m_rel[0], m_tmo[0],
            m_act[1], m_act[1] | m_rel[1],
            m_rel[1], m_tmo[1], m_conf};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.req_0, bus.busy_0,
            bus.done_0, bus.timeout_0,
            bus.req_1, bus.busy_1,
            bus.done_1, bus.timeout_1,
            bus.gnt_conflict};
  endfunction

  task automatic check(input string nm,
                       input logic [8:0] got,
                       input logic [8:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b want %b",
               nm, $time, got, want);
    end
  endtask

  task automatic check_int(input string nm,
                           input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, got, want);
    end
  endtask

  task automatic step(input bit r,
    input bit s0, input int l0, input bit g0,
    input bit s1, input int l1, input bit g1);
    rst         = r;
    bus.start_0 = s0;
    bus.len_0   = 4'(l0);
    bus.gnt_0   = g0;
    bus.start_1 = s1;
    bus.len_1   = 4'(l1);
    bus.gnt_1   = g1;
    @(posedge clk);
    model_step(r, s0, l0, g0, s1, l1, g1);
    #1;
  endtask

  task automatic stepm(input string nm, input bit r,
    input bit s0, input int l0, input bit g0,
    input bit s1, input int l1, input bit g1);
    step(r, s0, l0, g0, s1, l1, g1);
    check(nm, dut_vec(), model_vec());
  endtask

  // {r0 b0 d0 t0 r1 b1 d1 t1 conflict}
  typedef struct {
    bit         r;
    bit         s0;
    int         l0;
    bit         g0;
    bit         s1;
    int         l1;
    bit         g1;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  int c_req;
  int c_done;
  int c_tmo;
  int c_done1;
  int gp;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start_0 = 1'b0;
    bus.start_1 = 1'b0;
    bus.len_0 = '0;
    bus.len_1 = '0;
    bus.gnt_0 = 1'b0;
    bus.gnt_1 = 1'b0;

    // 3-beat burst, repeated starts, grants while idle
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 9'b0000_0000_0});
    tbl.push_back('{0, 1, 2, 0, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 9'b0110_0000_0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 9'b0000_0000_0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 1, 3, 1, 0, 0, 0, 9'b0110_0000_0});
    tbl.push_back('{0, 1, 3, 0, 0, 0, 0, 9'b0000_0000_0});
    tbl.push_back('{0, 1, 3, 0, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 9'b1100_0000_0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 9'b0110_0000_0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 9'b0000_0000_0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 1, 9'b0000_0000_1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 9'b0000_0000_1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 9'b0000_0000_0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 9'b0000_1100_0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 9'b0000_0110_0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 9'b0000_0000_0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].s0, tbl[i].l0, tbl[i].g0,
           tbl[i].s1, tbl[i].l1, tbl[i].g1);
      check($sformatf("tbl[%0d]", i), dut_vec(),
            tbl[i].exp);
    end

    // channel 1 never granted: 15 request cycles then timeout
    stepm("tmo_start", 0, 0, 0, 0, 1, 0, 0);
    c_req = 32'(bus.req_1);
    c_tmo = 0;
    c_done = 0;
    for (int i = 0; i < 19; i++) begin
      stepm("tmo_wait", 0, 0, 0, 0, 0, 0, 0);
      c_req  += 32'(bus.req_1);
      c_tmo  += 32'(bus.timeout_1);
      c_done += 32'(bus.done_1);
    end
    check_int("tmo_req_cycles", c_req, TMO);
    check_int("tmo_pulses", c_tmo, 1);
    check_int("tmo_no_done", c_done, 0);

    // pre-empted 4-beat burst: grants 2 on, 3 off, 2 on
    stepm("pre_start", 0, 1, 3, 0, 0, 0, 0);
    c_req = 32'(bus.req_0);
    c_done = 0;
    for (int i = 0; i < 10; i++) begin
      gp = (i == 1 || i == 2 || i == 6 || i == 7);
      stepm("pre_run", 0, 0, 0, gp[0], 0, 0, 0);
      c_req  += 32'(bus.req_0);
      c_done += 32'(bus.done_0);
    end
    check_int("pre_req_cycles", c_req, 8);
    check_int("pre_done", c_done, 1);

    // both channels, alternating grants
    stepm("alt_start", 0, 1, 1, 0, 1, 1, 0);
    c_done = 0;
    c_done1 = 0;
    for (int i = 0; i < 6; i++) begin
      gp = (i < 4) ? (i % 2) : 2;
      stepm("alt_run", 0, 0, 0, gp == 0,
            0, 0, gp == 1);
      c_done  += 32'(bus.done_0);
      c_done1 += 32'(bus.done_1);
    end
    check_int("alt_done0", c_done, 1);
    check_int("alt_done1", c_done1, 1);
    check_int("alt_no_conf", 32'(bus.gnt_conflict), 0);
    stepm("conf_set", 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      stepm("conf_hold", 0, 0, 0, 0, 0, 0, 0);
    check_int("conf_sticky", 32'(bus.gnt_conflict), 1);
    stepm("conf_rst", 1, 0, 0, 0, 0, 0, 0);
    check_int("conf_clear", 32'(bus.gnt_conflict), 0);

    // reset in the middle of an owned burst
    stepm("mid_start", 0, 1, 3, 0, 0, 0, 0);
    stepm("mid_g1", 0, 0, 0, 1, 0, 0, 0);
    stepm("mid_g2", 0, 0, 0, 1, 0, 0, 0);
    stepm("mid_rst", 1, 0, 0, 1, 0, 0, 0);
    check_int("mid_req", 32'(bus.req_0), 0);
    check_int("mid_busy", 32'(bus.busy_0), 0);
    stepm("mid_restart", 0, 1, 0, 0, 0, 0, 0);
    check_int("mid_busy_again", 32'(bus.busy_0), 1);
    stepm("mid_fin", 0, 0, 0, 1, 0, 0, 0);
    check_int("mid_done", 32'(bus.done_0), 1);
    stepm("mid_idle", 0, 0, 0, 0, 0, 0, 0);

    // random traffic with varying grant density
    gp = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) gp = $urandom_range(0, 4) * 25;
      stepm("rand", $urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 15),
            $urandom_range(0, 99) < gp,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 15),
            $urandom_range(0, 99) < gp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
